// File: rtl/hazard_pkg.sv
// Shared types, defaults and helpers for the pipeline hazard controller.
//   state_t        : controller FSM encoding
//   MC_LAT_DEF     : default E-stage occupancy of a multi-cycle ALU op
//   MEM_TO_DEF     : default memory-wait timeout in cycles
//   load_use_hit() : load-use hazard detection between D and E
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int unsigned MC_LAT_DEF = 4;
    localparam int unsigned MEM_TO_DEF = 255;

    // Register indices are passed zero-extended to 32 bits so one function
    // serves any register-index width up to 32.
    function automatic logic load_use_hit(
        input logic        regmem_e,
        input logic        regw_e,
        input logic        use_a,
        input logic        use_b,
        input logic [31:0] src_a,
        input logic [31:0] src_b,
        input logic [31:0] dst_e
    );
        return regmem_e & regw_e &
               ((use_a & (src_a == dst_e)) | (use_b & (src_b == dst_e)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high clear
//   en    : count this cycle
//   count : current value, holds at all-ones
module sat_counter #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [N-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Drives stall/flush of the F/D, D/E and E/M registers for load-use
// hazards, taken branches / PC loads, multi-cycle ALU ops and data-memory
// wait states, and counts stalled fetch cycles.
//   clk, rst                  : clock, synchronous active-high reset
//   srcA_D, srcB_D, useA_D/B  : sources read by the instruction in D
//   dst_E, regw_E, regmem_E   : destination / write / load of E instruction
//   taken_E, pcload_E         : control transfer resolved in E
//   mc_E                      : E holds a multi-cycle ALU op
//   memreq_M, mem_ready       : M-stage data memory handshake
//   stall_F/D/E/M             : hold the corresponding pipeline register
//   flush_D, flush_E          : clear F/D and D/E at the next edge
//   busy                      : FSM not in RUN
//   mem_err                   : sticky memory-timeout flag
//   stall_cnt                 : saturating count of cycles with stall_F=1
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned M      = 4,
    parameter int unsigned N      = 32,
    parameter int unsigned MC_LAT = MC_LAT_DEF,
    parameter int unsigned MEM_TO = MEM_TO_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] srcA_D,
    input  logic [M-1:0] srcB_D,
    input  logic         useA_D,
    input  logic         useB_D,
    input  logic [M-1:0] dst_E,
    input  logic         regw_E,
    input  logic         regmem_E,
    input  logic         taken_E,
    input  logic         pcload_E,
    input  logic         mc_E,
    input  logic         memreq_M,
    input  logic         mem_ready,
    output logic         stall_F,
    output logic         stall_D,
    output logic         stall_E,
    output logic         stall_M,
    output logic         flush_D,
    output logic         flush_E,
    output logic         busy,
    output logic         mem_err,
    output logic [N-1:0] stall_cnt
);

    localparam int unsigned MC_W = $clog2(MC_LAT);
    localparam int unsigned TO_W = $clog2(MEM_TO + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_LAT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TO);

    state_t          state, state_nxt;
    logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            mem_wait;
    logic            hazard;

    assign mem_wait = memreq_M & ~mem_ready;
    assign hazard   = load_use_hit(regmem_E, regw_E, useA_D, useB_D,
                                   32'(srcA_D), 32'(srcB_D), 32'(dst_E));

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            mc_cnt  <= '0;
            to_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
            to_cnt <= to_cnt_nxt;
            // Flag fires on the edge where the wait counter reaches the limit.
            if ((state_nxt == MEM_WAIT) && (to_cnt_nxt == TO_MAX))
                mem_err <= 1'b1;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        to_cnt_nxt = to_cnt;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt  = MEM_WAIT;
                    to_cnt_nxt = TO_W'(1);
                end else if (mc_E) begin
                    state_nxt  = MC_BUSY;
                    mc_cnt_nxt = MC_W'(1);
                end
            end
            MC_BUSY: begin
                // A memory wait parks the op; mc_cnt stays frozen in MEM_WAIT
                // and the op resumes from MEM_WAIT back into MC_BUSY.
                if (mem_wait) begin
                    state_nxt  = MEM_WAIT;
                    to_cnt_nxt = TO_W'(1);
                end else if (mc_cnt == MC_LAST) begin
                    state_nxt  = RUN;
                    mc_cnt_nxt = '0;
                end else begin
                    mc_cnt_nxt = mc_cnt + 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt  = (mc_cnt != '0) ? MC_BUSY : RUN;
                    to_cnt_nxt = '0;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Outputs
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        busy    = 1'b0;
        if (rst) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else begin
            busy = (state != RUN);
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        {stall_F, stall_D, stall_E, stall_M} = '1;
                    end else if (mc_E) begin
                        {stall_F, stall_D, stall_E} = '1;
                    end else if (taken_E | pcload_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (hazard) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mem_wait)
                        {stall_F, stall_D, stall_E, stall_M} = '1;
                    else if (mc_cnt != MC_LAST)
                        {stall_F, stall_D, stall_E} = '1;
                end
                MEM_WAIT: begin
                    if (!mem_ready)
                        {stall_F, stall_D, stall_E, stall_M} = '1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.N(N)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_F),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_LAT=4, MEM_TO=8, N=4).
// Output vector order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, busy}
module tb_hazard_ctrl;

    localparam int unsigned M      = 4;
    localparam int unsigned N      = 4;
    localparam int unsigned MC_LAT = 4;
    localparam int unsigned MEM_TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] srcA_D, srcB_D, dst_E;
    logic         useA_D, useB_D, regw_E, regmem_E;
    logic         taken_E, pcload_E, mc_E, memreq_M, mem_ready;
    logic         stall_F, stall_D, stall_E, stall_M;
    logic         flush_D, flush_E, busy, mem_err;
    logic [N-1:0] stall_cnt;
    logic [6:0]   outs;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign outs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, busy};

    hazard_ctrl #(.M(M), .N(N), .MC_LAT(MC_LAT), .MEM_TO(MEM_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .srcA_D    (srcA_D),
        .srcB_D    (srcB_D),
        .useA_D    (useA_D),
        .useB_D    (useB_D),
        .dst_E     (dst_E),
        .regw_E    (regw_E),
        .regmem_E  (regmem_E),
        .taken_E   (taken_E),
        .pcload_E  (pcload_E),
        .mc_E      (mc_E),
        .memreq_M  (memreq_M),
        .mem_ready (mem_ready),
        .stall_F   (stall_F),
        .stall_D   (stall_D),
        .stall_E   (stall_E),
        .stall_M   (stall_M),
        .flush_D   (flush_D),
        .flush_E   (flush_E),
        .busy      (busy),
        .mem_err   (mem_err),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic idle;
        srcA_D = '0; srcB_D = '0; dst_E = '0;
        useA_D = 0; useB_D = 0; regw_E = 0; regmem_E = 0;
        taken_E = 0; pcload_E = 0; mc_E = 0; memreq_M = 0; mem_ready = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load(input logic [M-1:0] dst);
        regmem_E = 1; regw_E = 1; dst_E = dst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        rst = 1'b1;
        idle();
        sample();
        check("rst_outs", 32'(outs), 32'(7'b0000110));
        tick();
        tick();
        rst = 1'b0;
        sample();
        check("post_rst_outs", 32'(outs), 32'(7'b0000000));
        check("post_rst_cnt", 32'(stall_cnt), 0);
        check("post_rst_err", 32'(mem_err), 0);
        tick();

        // Load-use on source A
        set_load(4'd3); srcA_D = 4'd3; useA_D = 1;
        sample();
        check("lu_a", 32'(outs), 32'(7'b1100010));
        tick();
        srcA_D = 4'd4;
        sample();
        check("lu_a_nomatch", 32'(outs), 32'(7'b0000000));
        check("lu_cnt1", 32'(stall_cnt), 1);
        tick();
        // Source B match, A unused though equal
        srcA_D = 4'd3; useA_D = 0; srcB_D = 4'd3; useB_D = 1;
        sample();
        check("lu_b", 32'(outs), 32'(7'b1100010));
        tick();
        useB_D = 0;
        sample();
        check("lu_unused", 32'(outs), 32'(7'b0000000));
        tick();
        useA_D = 1; regmem_E = 0;
        sample();
        check("lu_not_load", 32'(outs), 32'(7'b0000000));
        tick();

        // Taken branch beats simultaneous load-use
        regmem_E = 1; taken_E = 1;
        sample();
        check("br_lu", 32'(outs), 32'(7'b0000110));
        tick();
        idle(); pcload_E = 1;
        sample();
        check("pcload", 32'(outs), 32'(7'b0000110));
        check("br_cnt", 32'(stall_cnt), 2);
        tick();

        // Multi-cycle op, taken_E ignored while busy
        do_reset();
        mc_E = 1;
        sample();
        check("mc_c0", 32'(outs), 32'(7'b1110000));
        tick();
        taken_E = 1;
        for (int unsigned i = 1; i < MC_LAT - 1; i++) begin
            sample();
            check($sformatf("mc_c%0d", i), 32'(outs), 32'(7'b1110001));
            tick();
        end
        sample();
        check("mc_last", 32'(outs), 32'(7'b0000001));
        tick();
        idle();
        sample();
        check("mc_done", 32'(outs), 32'(7'b0000000));
        check("mc_cnt", 32'(stall_cnt), 3);
        tick();

        // Memory wait of 5 cycles
        do_reset();
        memreq_M = 1;
        sample();
        check("mw_c0", 32'(outs), 32'(7'b1111000));
        tick();
        for (int unsigned i = 1; i < 5; i++) begin
            sample();
            check($sformatf("mw_c%0d", i), 32'(outs), 32'(7'b1111001));
            tick();
        end
        mem_ready = 1;
        sample();
        check("mw_ready", 32'(outs), 32'(7'b0000001));
        tick();
        idle();
        sample();
        check("mw_done", 32'(outs), 32'(7'b0000000));
        check("mw_cnt", 32'(stall_cnt), 5);
        check("mw_err", 32'(mem_err), 0);
        tick();

        // Memory wait nested inside a multi-cycle op
        do_reset();
        mc_E = 1;
        sample();
        check("nest_c0", 32'(outs), 32'(7'b1110000));
        tick();
        memreq_M = 1;
        sample();
        check("nest_mw1", 32'(outs), 32'(7'b1111001));
        tick();
        sample();
        check("nest_mw2", 32'(outs), 32'(7'b1111001));
        tick();
        mem_ready = 1;
        sample();
        check("nest_rdy", 32'(outs), 32'(7'b0000001));
        tick();
        memreq_M = 0; mem_ready = 0;
        sample();
        check("nest_res1", 32'(outs), 32'(7'b1110001));
        tick();
        sample();
        check("nest_res2", 32'(outs), 32'(7'b1110001));
        tick();
        sample();
        check("nest_last", 32'(outs), 32'(7'b0000001));
        tick();
        mc_E = 0;
        sample();
        check("nest_done", 32'(outs), 32'(7'b0000000));
        tick();

        // Timeout, counter saturation, reset mid-wait
        do_reset();
        memreq_M = 1;
        for (int unsigned i = 0; i < MEM_TO; i++) begin
            sample();
            if (i == MEM_TO - 1)
                check("to_before", 32'(mem_err), 0);
            tick();
        end
        sample();
        check("to_set", 32'(mem_err), 1);
        check("to_hold", 32'(outs), 32'(7'b1111001));
        for (int unsigned i = MEM_TO; i < 20; i++) begin
            if (i == 14)
                check("sat_14", 32'(stall_cnt), 14);
            tick();
            sample();
        end
        check("sat_15", 32'(stall_cnt), 15);
        check("to_sticky", 32'(mem_err), 1);
        check("to_still", 32'(outs), 32'(7'b1111001));
        tick();
        rst = 1;
        sample();
        check("to_rst_outs", 32'(outs), 32'(7'b0000110));
        tick();
        rst = 0;
        idle();
        sample();
        check("to_rst_state", 32'(outs), 32'(7'b0000000));
        check("to_rst_err", 32'(mem_err), 0);
        check("to_rst_cnt", 32'(stall_cnt), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
